// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Initiator side of the data-memory port. A load/store request is accepted
//   over req_valid/req_ready, the byte address base+offset is formed and range
//   checked, and the unit drives a byte-addressed, 64-bit wide data memory.
//   Byte/half/word stores are done as read-modify-write of the doubleword at
//   the target address. Loads return the low 1/2/4/8 bytes, sign- or
//   zero-extended to 64 bits.
//
//   Handshakes: a transfer happens on a posedge where valid and ready are
//   both 1. valid, once raised, is held with its payload stable until that
//   edge. ready may be raised or dropped at any time and never depends
//   combinationally on valid.
//
// Ports
//   clk, reset_n                  clock; asynchronous active-low reset
//   req_valid / req_ready         request handshake (ready only in IDLE)
//   req_write, req_size,
//   req_unsigned, req_base,
//   req_offset, req_wdata         request payload, sampled only at accept
//   resp_valid / resp_ready       response handshake, response held until taken
//   resp_rdata, resp_err          load result (0 for stores/errors), range error
//   Mem_Addr, Write_Data,
//   Mem_Read, Mem_Write           memory command, all registered
//   Read_Data                     combinational read data from memory
//   dbg_state                     current FSM state
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_BYTES = 100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_base,
    input  logic [63:0] req_offset,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] Mem_Addr,
    output logic [63:0] Write_Data,
    output logic        Mem_Read,
    output logic        Mem_Write,
    input  logic [63:0] Read_Data,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_WR     = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    // Every access touches 8 bytes, so the highest legal start address is
    // MEM_BYTES-8. The compare is unsigned, which also rejects addresses that
    // wrapped below zero.
    localparam logic [63:0] LAST_LEGAL = 64'(MEM_BYTES - 8);

    state_t      state;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [63:0] wdata_q;

    logic [63:0] req_addr;
    logic        req_in_range;
    logic [63:0] size_mask;
    logic [63:0] load_value;
    logic [63:0] merged_data;
    logic        sign_bit;

    assign req_addr     = req_base + req_offset;
    assign req_in_range = (req_addr <= LAST_LEGAL);
    assign req_ready    = (state == S_IDLE);
    assign dbg_state    = state;

    // Byte-lane mask for the registered access size.
    always_comb begin
        case (size_q)
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    // Load extraction: keep the low N bytes, then fill the upper bytes with
    // the top bit of the field for signed sub-doubleword loads.
    always_comb begin
        case (size_q)
            2'd0:    sign_bit = Read_Data[7];
            2'd1:    sign_bit = Read_Data[15];
            2'd2:    sign_bit = Read_Data[31];
            default: sign_bit = 1'b0;
        endcase
        load_value = Read_Data & size_mask;
        if (!unsigned_q && sign_bit) begin
            load_value = load_value | ~size_mask;
        end
    end

    // Store merge: new low N bytes, untouched upper bytes from memory.
    assign merged_data = (Read_Data & ~size_mask) | (wdata_q & size_mask);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            Mem_Addr   <= '0;
            Write_Data <= '0;
            Mem_Read   <= 1'b0;
            Mem_Write  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        wdata_q    <= req_wdata;
                        if (!req_in_range) begin
                            // No memory access; Mem_Addr keeps its old value.
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!req_write) begin
                            state    <= S_RD;
                            Mem_Addr <= req_addr;
                            Mem_Read <= 1'b1;
                        end else if (req_size == 2'd3) begin
                            state      <= S_WR;
                            Mem_Addr   <= req_addr;
                            Write_Data <= req_wdata;
                            Mem_Write  <= 1'b1;
                        end else begin
                            state    <= S_RMW_RD;
                            Mem_Addr <= req_addr;
                            Mem_Read <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    state      <= S_RESP;
                    Mem_Read   <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_value;
                end
                S_RMW_RD: begin
                    state      <= S_WR;
                    Mem_Read   <= 1'b0;
                    Write_Data <= merged_data;
                    Mem_Write  <= 1'b1;
                end
                S_WR: begin
                    // Memory commits the doubleword on this edge.
                    state      <= S_RESP;
                    Mem_Write  <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    Mem_Read  <= 1'b0;
                    Mem_Write <= 1'b0;
                end
            endcase
        end
    end

endmodule
